// File: rtl/input_feeder.sv
// rtl/input_feeder.sv - batch loader and skewed dequeue sequencer for the input_acc row lanes
module input_feeder #(
    parameter int ROWS   = 4,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [7:0]               num_vec,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic signed [15:0]       mem_rd_data,
    output logic [ROWS-1:0]          acc_wr_en,
    output logic signed [15:0]       acc_wr_data,
    output logic [ROWS-1:0]          acc_rd_en,
    output logic                     busy,
    output logic                     done
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t          state;
    logic [7:0]      n_lat;
    logic [15:0]     load_last;
    logic [15:0]     cnt;
    logic [RW-1:0]   rd_row;
    logic            flush_cnt;
    logic            p1_valid;
    logic [RW-1:0]   p1_row;
    logic [7:0]      n_eff;
    logic [15:0]     drain_last;

    // Batch size is clamped to the lane depth so a lane can never overflow.
    assign n_eff      = (num_vec > 8'(DEPTH)) ? 8'(DEPTH) : num_vec;
    assign drain_last = {8'd0, n_lat} + 16'(ROWS) - 16'd2;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // Lane r dequeues during drain steps r .. r+N-1, giving the diagonal wavefront.
    function automatic logic [ROWS-1:0] rd_pattern(input logic [15:0] d, input logic [7:0] n);
        logic [ROWS-1:0] p;
        p = '0;
        for (int r = 0; r < ROWS; r++)
            p[r] = (d >= 16'(r)) && (d < 16'(r) + {8'd0, n});
        return p;
    endfunction

    // Sequencer: read addresses during LOAD, pipeline flush, then skewed dequeue strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            n_lat     <= '0;
            load_last <= '0;
            cnt       <= '0;
            rd_row    <= '0;
            flush_cnt <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            acc_rd_en <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_lat     <= n_eff;
                        load_last <= 16'(ROWS) * {8'd0, n_eff} - 16'd1;
                        cnt       <= '0;
                        rd_row    <= '0;
                        if (n_eff == 8'd0) begin
                            state <= ST_DONE;
                        end else begin
                            state     <= ST_LOAD;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= base_addr;
                        end
                    end
                end
                ST_LOAD: begin
                    if (cnt == load_last) begin
                        mem_rd_en <= 1'b0;
                        mem_addr  <= '0;
                        flush_cnt <= 1'b0;
                        state     <= ST_FLUSH;
                    end else begin
                        cnt      <= cnt + 16'd1;
                        mem_addr <= mem_addr + ADDR_W'(1);
                        rd_row   <= (rd_row == RW'(ROWS - 1)) ? '0 : rd_row + RW'(1);
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt) begin
                        cnt       <= '0;
                        acc_rd_en <= rd_pattern(16'd0, n_lat);
                        state     <= ST_DRAIN;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == drain_last) begin
                        acc_rd_en <= '0;
                        state     <= ST_DONE;
                    end else begin
                        cnt       <= cnt + 16'd1;
                        acc_rd_en <= rd_pattern(cnt + 16'd1, n_lat);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Write path: tag each read with its row, capture returning data, emit one-hot lane strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_valid    <= 1'b0;
            p1_row      <= '0;
            acc_wr_en   <= '0;
            acc_wr_data <= '0;
        end else begin
            p1_valid <= mem_rd_en;
            p1_row   <= rd_row;
            if (p1_valid) begin
                acc_wr_en   <= ROWS'(1) << p1_row;
                acc_wr_data <= mem_rd_data;
            end else begin
                acc_wr_en   <= '0;
                acc_wr_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_input_feeder.sv
// tb/tb_input_feeder.sv - directed self-checking bench for input_feeder
module tb_input_feeder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  num_vec;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rd_data;
    logic [3:0]  acc_wr_en;
    logic [15:0] acc_wr_data;
    logic [3:0]  acc_rd_en;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    logic [15:0] mem [256];
    logic [15:0] lane_q [4][$];
    int          deq_cnt [4];
    logic [3:0]  rd_hist [64];
    logic [7:0]  addr_hist [64];

    input_feeder #(.ROWS(4), .DEPTH(4), .ADDR_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .num_vec(num_vec),
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data),
        .acc_wr_en(acc_wr_en),
        .acc_wr_data(acc_wr_data),
        .acc_rd_en(acc_rd_en),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unified buffer model: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en)
            mem_rd_data <= mem[mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Cycle 0 is the current cycle; returns in the first IDLE cycle after done.
    task automatic run_batch(input logic [7:0] base, input logic [7:0] nv,
                             input bit pulse, input bit hold);
        int n, l, dc, k, d;
        logic [3:0] e_wr, e_rd;
        logic [15:0] e_data;
        logic [7:0] e_addr;
        n  = (nv > 8'd4) ? 4 : int'(nv);
        l  = 4 * n;
        dc = (n == 0) ? 1 : l + n + 6;
        for (int r = 0; r < 4; r++) begin
            lane_q[r].delete();
            deq_cnt[r] = 0;
        end
        base_addr = base;
        num_vec   = nv;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= dc + 1; c++) begin
            e_addr = ((c >= 1) && (c <= l)) ? 8'(int'(base) + c - 1) : 8'd0;
            e_wr   = 4'd0;
            e_data = 16'd0;
            if ((c >= 3) && (c <= l + 2)) begin
                k      = c - 3;
                e_wr   = 4'd1 << (k % 4);
                e_data = mem[8'(int'(base) + k)];
            end
            e_rd = 4'd0;
            if ((c >= l + 3) && (c <= l + n + 5)) begin
                d = c - l - 3;
                for (int r = 0; r < 4; r++)
                    e_rd[r] = (r <= d) && (d < r + n);
            end
            chk("mem_rd_en", 32'(mem_rd_en), 32'((c >= 1) && (c <= l)));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("acc_wr_en", 32'(acc_wr_en), 32'(e_wr));
            chk("acc_wr_data", 32'(acc_wr_data), 32'(e_data));
            chk("acc_rd_en", 32'(acc_rd_en), 32'(e_rd));
            chk("busy", 32'(busy), 32'(c <= dc));
            chk("done", 32'(done), 32'(c == dc));
            rd_hist[c]   = acc_rd_en;
            addr_hist[c] = mem_addr;
            for (int r = 0; r < 4; r++) begin
                if (acc_wr_en[r]) lane_q[r].push_back(acc_wr_data);
                if (acc_rd_en[r]) deq_cnt[r]++;
            end
            if (pulse && (c == 2 || c == l + 4)) start = 1'b1;
            else if (pulse) start = 1'b0;
            if (hold && c == dc) start = 1'b1;
            if (c != dc + 1) step();
        end
        for (int r = 0; r < 4; r++) begin
            chk("lane_writes", 32'(lane_q[r].size()), 32'(n));
            chk("lane_deq", 32'(deq_cnt[r]), 32'(n));
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        mem[8'hFE] = 16'h8000;
        mem[8'hFF] = 16'hFFFF;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = 8'd0;
        num_vec   = 8'd0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_wr_en", 32'(acc_wr_en), 32'd0);
        chk("rst_acc_rd_en", 32'(acc_rd_en), 32'd0);
        rst = 1'b0;
        step();

        // Basic batch with stray start pulses during LOAD and DRAIN.
        run_batch(8'h10, 8'd4, 1'b1, 1'b0);
        chk("lane2_v0", 32'(lane_q[2][0]), 32'h12);
        chk("lane2_v1", 32'(lane_q[2][1]), 32'h16);
        chk("lane2_v2", 32'(lane_q[2][2]), 32'h1A);
        chk("lane2_v3", 32'(lane_q[2][3]), 32'h1E);
        chk("rd0_c19", 32'(rd_hist[19][0]), 32'd1);
        chk("rd0_c23", 32'(rd_hist[23][0]), 32'd0);
        chk("rd3_c21", 32'(rd_hist[21][3]), 32'd0);
        chk("rd3_c25", 32'(rd_hist[25][3]), 32'd1);

        // Address wrap and negative data passthrough.
        run_batch(8'hFC, 8'd2, 1'b0, 1'b0);
        chk("wrap_a4", 32'(addr_hist[4]), 32'hFF);
        chk("wrap_a5", 32'(addr_hist[5]), 32'h00);
        chk("wrap_a8", 32'(addr_hist[8]), 32'h03);
        chk("neg_8000", 32'(lane_q[2][0]), 32'h8000);
        chk("neg_ffff", 32'(lane_q[3][0]), 32'hFFFF);
        chk("wrap_lane3_v1", 32'(lane_q[3][1]), 32'h0003);

        // Empty batch and oversize clamp.
        run_batch(8'h20, 8'd0, 1'b0, 1'b0);
        run_batch(8'h30, 8'd9, 1'b0, 1'b0);

        // N=1, start held across done to chain a second batch.
        run_batch(8'h40, 8'd1, 1'b0, 1'b1);
        chk("n1_d0", 32'(rd_hist[7]), 32'b0001);
        chk("n1_d1", 32'(rd_hist[8]), 32'b0010);
        chk("n1_d2", 32'(rd_hist[9]), 32'b0100);
        chk("n1_d3", 32'(rd_hist[10]), 32'b1000);
        run_batch(8'h50, 8'd1, 1'b0, 1'b0);

        // Reset in cycle 8 of a batch.
        base_addr = 8'h10;
        num_vec   = 8'd4;
        start     = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_wr_en", 32'(acc_wr_en), 32'd0);
        chk("mid_rst_wr_data", 32'(acc_wr_data), 32'd0);
        chk("mid_rst_acc_rd", 32'(acc_rd_en), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        step();
        run_batch(8'h60, 8'd3, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
